// File: rtl/itcounts_pkg.sv
// Shared definitions for the 2-bit mode-selectable counter and its checker:
// select encodings, checker FSM states and the per-mode sequence functions.
package itcounts_pkg;

  localparam logic [1:0] SEL_UP    = 2'b00;  // 0,1,2,3
  localparam logic [1:0] SEL_DN    = 2'b01;  // 3,2,1,0
  localparam logic [1:0] SEL_GRAY  = 2'b10;  // 0,1,3,2
  localparam logic [1:0] SEL_RGRAY = 2'b11;  // 0,2,3,1

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_TRACK = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  // Successor of val in the sequence for mode sel (wraps after the last value).
  function automatic logic [1:0] seq_next(input logic [1:0] val, input logic [1:0] sel);
    logic [1:0] r;
    r = '0;
    unique case (sel)
      SEL_UP:   r = val + 2'd1;
      SEL_DN:   r = val - 2'd1;
      SEL_GRAY: begin
        unique case (val)
          2'd0: r = 2'd1;
          2'd1: r = 2'd3;
          2'd3: r = 2'd2;
          2'd2: r = 2'd0;
        endcase
      end
      SEL_RGRAY: begin
        unique case (val)
          2'd0: r = 2'd2;
          2'd2: r = 2'd3;
          2'd3: r = 2'd1;
          2'd1: r = 2'd0;
        endcase
      end
    endcase
    return r;
  endfunction

  // Value on which the terminal flag must be asserted for mode sel.
  function automatic logic [1:0] seq_last(input logic [1:0] sel);
    logic [1:0] r;
    r = '0;
    unique case (sel)
      SEL_UP:    r = 2'd3;
      SEL_DN:    r = 2'd0;
      SEL_GRAY:  r = 2'd2;
      SEL_RGRAY: r = 2'd1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/itcounts_seq_rom.sv
// Combinational sequence lookup for the 2-bit mode-selectable counter.
//   prev     : current counter value
//   select   : counter mode
//   exp_next : value that must follow prev in this mode
//   last_val : terminal value of this mode
module itcounts_seq_rom
  import itcounts_pkg::*;
(
  input  logic [1:0] prev,
  input  logic [1:0] select,
  output logic [1:0] exp_next,
  output logic [1:0] last_val
);

  always_comb begin
    exp_next = seq_next(prev, select);
    last_val = seq_last(select);
  end

endmodule

// File: rtl/itcounts_checker.sv
// Sequence checker for the 2-bit mode-selectable counter. Follows the counter
// stream while En is high, flags out-of-sequence steps and incoherent terminal
// flags, and counts completed laps (saturating).
//   Clock, Reset(async, active low), En, select, Counter_In, out1_in, Clear : inputs
//   Locked    : high while tracking
//   Err_Pulse : one-cycle pulse per detected violation
//   Seq_Err   : sticky error flag
//   Lap_Count : completed laps, saturating at all-ones
//   State     : FSM state (IDLE=0, SYNC=1, TRACK=2, ERROR=3)
module itcounts_checker
  import itcounts_pkg::*;
#(
  parameter int unsigned LAP_W   = 8,
  parameter int unsigned HOLD_OK = 0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             En,
  input  logic [1:0]       select,
  input  logic [1:0]       Counter_In,
  input  logic             out1_in,
  input  logic             Clear,
  output logic             Locked,
  output logic             Err_Pulse,
  output logic             Seq_Err,
  output logic [LAP_W-1:0] Lap_Count,
  output logic [1:0]       State
);

  state_t     state;
  logic [1:0] prev_val;
  logic [1:0] prev_sel;
  logic [1:0] exp_next;
  logic [1:0] last_val;

  logic is_last;
  logic is_hold;
  logic term_ok;
  logic step_ok;
  logic sel_chg;

  itcounts_seq_rom u_rom (
    .prev     (prev_val),
    .select   (select),
    .exp_next (exp_next),
    .last_val (last_val)
  );

  always_comb begin
    is_last = (Counter_In == last_val);
    is_hold = (Counter_In == prev_val);
    term_ok = (out1_in == is_last);
    step_ok = ((Counter_In == exp_next) || ((HOLD_OK != 0) && is_hold)) && term_ok;
    sel_chg = (select != prev_sel);
  end

  // A sample that would be a violation in the same cycle as Clear is forgiven:
  // the FSM carries on as if it were legal, resynchronising prev to the sample.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      prev_val  <= '0;
      prev_sel  <= '0;
      Err_Pulse <= 1'b0;
      Seq_Err   <= 1'b0;
      Lap_Count <= '0;
    end else begin
      Err_Pulse <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (En) begin
            state    <= ST_SYNC;
            prev_val <= Counter_In;
            prev_sel <= select;
          end
        end
        ST_SYNC: begin
          if (!En) begin
            state <= ST_IDLE;
          end else begin
            prev_val <= Counter_In;
            prev_sel <= select;
            if (!term_ok && !Clear) begin
              state     <= ST_ERROR;
              Err_Pulse <= 1'b1;
              Seq_Err   <= 1'b1;
            end else begin
              state <= ST_TRACK;
            end
          end
        end
        ST_TRACK: begin
          if (!En) begin
            state <= ST_IDLE;
          end else if (sel_chg) begin
            state    <= ST_SYNC;
            prev_val <= Counter_In;
            prev_sel <= select;
          end else if (step_ok) begin
            prev_val <= Counter_In;
            if (is_last && !is_hold && (Lap_Count != '1))
              Lap_Count <= Lap_Count + 1'b1;
          end else if (Clear) begin
            prev_val <= Counter_In;
          end else begin
            state     <= ST_ERROR;
            Err_Pulse <= 1'b1;
            Seq_Err   <= 1'b1;
          end
        end
        ST_ERROR: begin
          if (Clear) state <= ST_IDLE;
        end
      endcase
      // Later non-blocking writes win, giving Clear priority over the above.
      if (Clear) begin
        Lap_Count <= '0;
        Seq_Err   <= 1'b0;
      end
    end
  end

  assign Locked = (state == ST_TRACK);
  assign State  = state;

endmodule
